// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package arm_mem_pkg;

    localparam int ARM_ADDR_W = 32;
    localparam int ARM_DATA_W = 32;
    localparam int ARM_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the arbiter's debug statistics.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// fetch port and the load/store port; read data returns one cycle after issue.
module mem_port_arbiter
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W = ARM_ADDR_W,
    parameter int DATA_W = ARM_DATA_W,
    parameter int CNT_W  = ARM_CNT_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              stall_f,
    output logic              stall_m,
    output logic [CNT_W-1:0]  i_grants,
    output logic [CNT_W-1:0]  d_grants,
    output logic [CNT_W-1:0]  conflicts
);

    state_t state_q, state_d;
    gnt_t   last_q, last_d;
    logic   dwe_q, dwe_d;
    logic   i_elig, d_elig, gnt_i, gnt_d, conflict;

    // A port is ineligible during its own ack cycle, so a held request is not re-issued.
    always_comb begin
        i_elig  = i_req && (state_q != BUSY_I) && !RESET;
        d_elig  = d_req && (state_q != BUSY_D) && !RESET;
        gnt_i   = i_elig && (!d_elig || (last_q == GNT_D));
        gnt_d   = d_elig && !gnt_i;
        state_d = IDLE;
        last_d  = last_q;
        dwe_d   = dwe_q;
        if (gnt_i) begin
            state_d = BUSY_I;
            last_d  = GNT_I;
        end else if (gnt_d) begin
            state_d = BUSY_D;
            last_d  = GNT_D;
            dwe_d   = d_we;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            last_q  <= GNT_D;
            dwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            dwe_q   <= dwe_d;
        end
    end

    assign m_en    = gnt_i || gnt_d;
    assign m_we    = gnt_d && d_we;
    assign m_addr  = gnt_i ? i_addr : (gnt_d ? d_addr : '0);
    assign m_wdata = gnt_d ? d_wdata : '0;

    assign i_ack   = (state_q == BUSY_I);
    assign d_ack   = (state_q == BUSY_D);
    assign i_rdata = i_ack ? m_rdata : '0;
    assign d_rdata = (d_ack && !dwe_q) ? m_rdata : '0;

    assign stall_f = i_req && !i_ack;
    assign stall_m = d_req && !d_ack;

    // Any outstanding request that did not win this cycle counts as contention.
    assign conflict = !RESET && ((stall_f && !gnt_i) || (stall_m && !gnt_d));

    sat_counter #(.CNT_W(CNT_W)) u_i_cnt (
        .CLK(CLK), .RESET(RESET), .inc(gnt_i), .count(i_grants)
    );
    sat_counter #(.CNT_W(CNT_W)) u_d_cnt (
        .CLK(CLK), .RESET(RESET), .inc(gnt_d), .count(d_grants)
    );
    sat_counter #(.CNT_W(CNT_W)) u_c_cnt (
        .CLK(CLK), .RESET(RESET), .inc(conflict), .count(conflicts)
    );

endmodule
